// File: rtl/btb_ras_pred.sv
// btb_ras_pred: fully-associative branch target buffer with a speculative,
// checkpointed, circular return-address stack.
//
// The fetch PC is registered. In the following cycle it is compared against
// the current array contents. The prediction outputs are driven combinationally
// from that registered lookup.
//
// Ports
//   clk, resetn       clock; synchronous active-low reset
//   fetch_en/pc       lookup request (registered)
//   pred_*            prediction for last cycle's lookup; pred_ckpt = {count, top}
//   upd_*             resolved-branch update from ID/EX, with RAS recovery
//   inv_all           flush every BTB entry and empty the RAS
module btb_ras_pred #(
  parameter int BTB_ENTRIES = 32,
  parameter int RAS_DEPTH   = 8,
  parameter int IDX_W       = $clog2(BTB_ENTRIES),
  parameter int RP_W        = $clog2(RAS_DEPTH),
  parameter int CK_W        = 2*RP_W+1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              fetch_en,
  input  logic [31:0]       fetch_pc,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  output logic [IDX_W-1:0]  pred_index,
  output logic [1:0]        pred_type,
  output logic [CK_W-1:0]   pred_ckpt,
  input  logic              upd_en,
  input  logic [31:0]       upd_pc,
  input  logic              upd_hit,
  input  logic [IDX_W-1:0]  upd_index,
  input  logic [1:0]        upd_type,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_mispredict,
  input  logic [CK_W-1:0]   upd_ckpt,
  input  logic              inv_all
);

  localparam logic [1:0]   T_COND  = 2'd0;
  localparam logic [1:0]   T_CALL  = 2'd2;
  localparam logic [1:0]   T_RET   = 2'd3;
  localparam logic [RP_W:0] C_DEPTH = (RP_W+1)'(RAS_DEPTH);

  // Two-bit saturating direction counter
  function automatic logic [1:0] f_ctr_upd(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'd1;
    else       return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  // Control state
  logic [BTB_ENTRIES-1:0] r_valid;
  logic [RP_W:0]          r_cnt;
  logic [RP_W-1:0]        r_top;
  logic [5:0]             r_lfsr;
  logic                   r_fen;
  logic [31:0]            r_fpc;

  // Entry and stack data (not reset; qualified by r_valid / r_cnt)
  logic [29:0] r_tag [BTB_ENTRIES];
  logic [29:0] r_tgt [BTB_ENTRIES];
  logic [1:0]  r_type[BTB_ENTRIES];
  logic [1:0]  r_ctr [BTB_ENTRIES];
  logic [29:0] r_ras [RAS_DEPTH];

  logic             w_hit;
  logic [IDX_W-1:0] w_idx;
  logic             w_pv;
  logic [1:0]       w_htype;
  logic             w_found_inv, w_found_cold;
  logic [IDX_W-1:0] w_inv_idx, w_cold_idx, w_rand, w_victim;
  logic             w_rec;
  logic [RP_W:0]    w_base_cnt, w_cnt_n;
  logic [RP_W-1:0]  w_base_top, w_top_n;
  logic [1:0]       w_act_type;
  logic             w_act_en;
  logic             w_push;
  logic [29:0]      w_push_data;
  logic             w_alloc;
  logic             w_unused;

  // Low PC/target bits are always zero for aligned instructions
  assign w_unused = ^{r_fpc[1:0], upd_pc[1:0], upd_target[1:0]};

  // Lookup: descending scan so the lowest matching index wins
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = BTB_ENTRIES-1; i >= 0; i--) begin
      if (r_valid[i] && (r_tag[i] == r_fpc[31:2])) begin
        w_hit = 1'b1;
        w_idx = IDX_W'(i);
      end
    end
  end

  assign w_pv    = r_fen & w_hit;
  assign w_htype = r_type[w_idx];

  always_comb begin
    pred_valid  = 1'b0;
    pred_taken  = 1'b0;
    pred_target = '0;
    pred_index  = '0;
    pred_type   = '0;
    if (w_pv) begin
      pred_valid  = 1'b1;
      pred_index  = w_idx;
      pred_type   = w_htype;
      pred_target = {r_tgt[w_idx], 2'b00};
      case (w_htype)
        T_COND:  pred_taken = r_ctr[w_idx][1];
        T_RET: begin
          pred_taken = (r_cnt != '0);
          if (r_cnt != '0) pred_target = {r_ras[r_top], 2'b00};
        end
        default: pred_taken = 1'b1;
      endcase
    end
  end

  assign pred_ckpt = {r_cnt, r_top};

  // Victim selection: free slot, then a cold conditional entry, then LFSR
  always_comb begin
    w_found_inv  = 1'b0;
    w_found_cold = 1'b0;
    w_inv_idx    = '0;
    w_cold_idx   = '0;
    w_rand       = '0;
    for (int i = BTB_ENTRIES-1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_found_inv = 1'b1;
        w_inv_idx   = IDX_W'(i);
      end
      if (r_valid[i] && (r_type[i] == T_COND) && (r_ctr[i] == 2'b00)) begin
        w_found_cold = 1'b1;
        w_cold_idx   = IDX_W'(i);
      end
    end
    for (int b = 0; b < IDX_W; b++) w_rand[b] = r_lfsr[b % 6];
  end

  assign w_victim = w_found_inv ? w_inv_idx : (w_found_cold ? w_cold_idx : w_rand);
  assign w_alloc  = upd_en & ~upd_hit & upd_taken;

  // RAS next state. A mispredict restores the checkpoint and replays the
  // resolved branch's own action; the speculative action of the same cycle
  // is discarded.
  assign w_rec = upd_en & upd_mispredict;

  always_comb begin
    w_base_cnt  = r_cnt;
    w_base_top  = r_top;
    w_act_type  = w_htype;
    w_act_en    = w_pv;
    w_push_data = r_fpc[31:2] + 30'd1;
    if (w_rec) begin
      w_base_cnt  = upd_ckpt[CK_W-1:RP_W];
      w_base_top  = upd_ckpt[RP_W-1:0];
      w_act_type  = upd_type;
      w_act_en    = 1'b1;
      w_push_data = upd_pc[31:2] + 30'd1;
    end
    w_cnt_n = w_base_cnt;
    w_top_n = w_base_top;
    w_push  = 1'b0;
    if (w_act_en) begin
      if (w_act_type == T_CALL) begin
        w_push  = 1'b1;
        w_top_n = w_base_top + 1'b1;
        w_cnt_n = (w_base_cnt == C_DEPTH) ? w_base_cnt : w_base_cnt + 1'b1;
      end else if ((w_act_type == T_RET) && (w_base_cnt != '0)) begin
        w_top_n = w_base_top - 1'b1;
        w_cnt_n = w_base_cnt - 1'b1;
      end
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_fen   <= 1'b0;
      r_fpc   <= '0;
      r_valid <= '0;
      r_cnt   <= '0;
      r_top   <= '0;
      r_lfsr  <= 6'b100010;
    end else begin
      r_fen  <= fetch_en;
      r_fpc  <= fetch_pc;
      r_lfsr <= {r_lfsr[4:0], r_lfsr[5] ^ r_lfsr[3] ^ r_lfsr[2]};
      if (inv_all) begin
        r_valid <= '0;
        r_cnt   <= '0;
        r_top   <= '0;
      end else begin
        r_cnt <= w_cnt_n;
        r_top <= w_top_n;
        if (w_alloc) r_valid[w_victim] <= 1'b1;
      end
    end
  end

  // Entry and stack data
  always_ff @(posedge clk) begin
    if (!inv_all && upd_en) begin
      if (upd_hit) begin
        r_type[upd_index] <= upd_type;
        r_tgt[upd_index]  <= upd_target[31:2];
        r_ctr[upd_index]  <= (upd_type == T_COND) ?
                             f_ctr_upd(r_ctr[upd_index], upd_taken) : 2'b11;
      end else if (upd_taken) begin
        r_tag[w_victim]  <= upd_pc[31:2];
        r_tgt[w_victim]  <= upd_target[31:2];
        r_type[w_victim] <= upd_type;
        r_ctr[w_victim]  <= (upd_type == T_COND) ? 2'b10 : 2'b11;
      end
    end
    if (!inv_all && w_push) r_ras[w_top_n] <= w_push_data;
  end

endmodule

// File: tb/tb_btb_ras_pred.sv
module tb_btb_ras_pred;

  logic        clk = 1'b0;
  logic        resetn;
  logic        fetch_en;
  logic [31:0] fetch_pc;
  logic        pred_valid, pred_taken;
  logic [31:0] pred_target;
  logic [4:0]  pred_index;
  logic [1:0]  pred_type;
  logic [6:0]  pred_ckpt;
  logic        upd_en, upd_hit, upd_taken, upd_mispredict, inv_all;
  logic [31:0] upd_pc, upd_target;
  logic [4:0]  upd_index;
  logic [1:0]  upd_type;
  logic [6:0]  upd_ckpt;

  int checks   = 0;
  int failures = 0;

  btb_ras_pred dut (
    .clk(clk), .resetn(resetn), .fetch_en(fetch_en), .fetch_pc(fetch_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_index(pred_index), .pred_type(pred_type), .pred_ckpt(pred_ckpt),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_hit(upd_hit), .upd_index(upd_index),
    .upd_type(upd_type), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .upd_ckpt(upd_ckpt), .inv_all(inv_all)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc);
    fetch_en = 1'b1;
    fetch_pc = pc;
    tick();
    fetch_en = 1'b0;
  endtask

  task automatic drive_upd(input logic hit, input logic [4:0] idx, input logic [1:0] ty,
                           input logic tk, input logic [31:0] pc, input logic [31:0] tgt,
                           input logic mp, input logic [6:0] ck);
    upd_en = 1'b1; upd_hit = hit; upd_index = idx; upd_type = ty; upd_taken = tk;
    upd_pc = pc; upd_target = tgt; upd_mispredict = mp; upd_ckpt = ck;
    tick();
    upd_en = 1'b0; upd_mispredict = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; fetch_en = 1'b1; fetch_pc = 32'h1C00_0010;
    upd_en = 0; upd_hit = 0; upd_index = 0; upd_type = 0; upd_taken = 0;
    upd_pc = 0; upd_target = 0; upd_mispredict = 0; upd_ckpt = 0; inv_all = 0;
    tick(); tick();
    fetch_en = 1'b0;
    checks++; if (pred_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", pred_valid); end
    checks++; if (pred_target !== 32'h0) begin failures++; $display("FAIL rst_target got=%0h exp=0", pred_target); end
    checks++; if (pred_ckpt !== 7'd0) begin failures++; $display("FAIL rst_ckpt got=%0h exp=0", pred_ckpt); end
    resetn = 1'b1;
    tick();
    fetch(32'h1C00_0000);
    checks++; if (pred_valid !== 1'b0) begin failures++; $display("FAIL t1_valid got=%0h exp=0", pred_valid); end
    checks++; if (pred_ckpt !== 7'd0) begin failures++; $display("FAIL t1_ckpt got=%0h exp=0", pred_ckpt); end
    checks++; if (pred_index !== 5'd0) begin failures++; $display("FAIL t1_index got=%0h exp=0", pred_index); end
  endtask

  task automatic test_cond();
    drive_upd(0, 0, 2'd0, 1, 32'h1C00_0010, 32'h1C00_0100, 0, 0);
    fetch(32'h1C00_0010);
    checks++; if (pred_valid !== 1'b1) begin failures++; $display("FAIL t2_valid got=%0h exp=1", pred_valid); end
    checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL t2_taken got=%0h exp=1", pred_taken); end
    checks++; if (pred_target !== 32'h1C00_0100) begin failures++; $display("FAIL t2_target got=%0h exp=1c000100", pred_target); end
    checks++; if (pred_index !== 5'd0) begin failures++; $display("FAIL t2_index got=%0h exp=0", pred_index); end
    checks++; if (pred_type !== 2'd0) begin failures++; $display("FAIL t2_type got=%0h exp=0", pred_type); end
    drive_upd(1, 0, 2'd0, 0, 32'h1C00_0010, 32'h1C00_0100, 0, 0);
    drive_upd(1, 0, 2'd0, 0, 32'h1C00_0010, 32'h1C00_0100, 0, 0);
    fetch(32'h1C00_0010);
    checks++; if (pred_valid !== 1'b1) begin failures++; $display("FAIL t2_nt_valid got=%0h exp=1", pred_valid); end
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL t2_nt_taken got=%0h exp=0", pred_taken); end
    drive_upd(1, 0, 2'd0, 0, 32'h1C00_0010, 32'h1C00_0100, 0, 0);
    fetch(32'h1C00_0010);
    checks++; if (pred_valid !== 1'b1) begin failures++; $display("FAIL t2_sat_valid got=%0h exp=1", pred_valid); end
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL t2_sat_taken got=%0h exp=0", pred_taken); end
    tick();
  endtask

  task automatic test_call_return();
    drive_upd(0, 0, 2'd2, 1, 32'h1C00_0020, 32'h1C00_1000, 0, 0);
    drive_upd(0, 0, 2'd3, 1, 32'h1C00_0200, 32'h1C00_0300, 0, 0);
    fetch(32'h1C00_0020);
    checks++; if (pred_valid !== 1'b1 || pred_type !== 2'd2) begin failures++; $display("FAIL t3_call got=%0h/%0h exp=1/2", pred_valid, pred_type); end
    checks++; if (pred_ckpt !== 7'd0) begin failures++; $display("FAIL t3_call_ckpt got=%0h exp=0", pred_ckpt); end
    checks++; if (pred_index !== 5'd1) begin failures++; $display("FAIL t3_call_index got=%0h exp=1", pred_index); end
    fetch(32'h1C00_0200);
    checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL t3_ret_taken got=%0h exp=1", pred_taken); end
    checks++; if (pred_target !== 32'h1C00_0024) begin failures++; $display("FAIL t3_ret_target got=%0h exp=1c000024", pred_target); end
    checks++; if (pred_ckpt !== 7'h09) begin failures++; $display("FAIL t3_ret_ckpt got=%0h exp=9", pred_ckpt); end
    fetch(32'h1C00_0200);
    checks++; if (pred_valid !== 1'b1 || pred_taken !== 1'b0) begin failures++; $display("FAIL t3_ret2 got=%0h/%0h exp=1/0", pred_valid, pred_taken); end
    checks++; if (pred_target !== 32'h1C00_0300) begin failures++; $display("FAIL t3_ret2_target got=%0h exp=1c000300", pred_target); end
    tick();
    checks++; if (pred_ckpt !== 7'd0) begin failures++; $display("FAIL t3_end_ckpt got=%0h exp=0", pred_ckpt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_t;
    for (int k = 0; k < 9; k++) drive_upd(0, 0, 2'd2, 1, 32'h1000 + 32'(16*k), 32'h8000, 0, 0);
    for (int k = 0; k < 9; k++) fetch(32'h1000 + 32'(16*k));
    for (int i = 0; i < 9; i++) begin
      fetch(32'h1C00_0200);
      if (i == 0) begin
        checks++; if (pred_ckpt !== 7'h41) begin failures++; $display("FAIL t4_full_ckpt got=%0h exp=41", pred_ckpt); end
      end
      if (i < 8) begin
        exp_t = 32'h1084 - 32'(16*i);
        checks++; if (pred_taken !== 1'b1 || pred_target !== exp_t) begin failures++; $display("FAIL t4_ret%0d got=%0h/%0h exp=1/%0h", i, pred_taken, pred_target, exp_t); end
      end else begin
        checks++; if (pred_valid !== 1'b1 || pred_taken !== 1'b0) begin failures++; $display("FAIL t4_ret8 got=%0h/%0h exp=1/0", pred_valid, pred_taken); end
      end
    end
    tick();
    checks++; if (pred_ckpt !== 7'h01) begin failures++; $display("FAIL t4_end_ckpt got=%0h exp=1", pred_ckpt); end
  endtask

  task automatic test_recovery();
    drive_upd(0, 0, 2'd2, 1, 32'h2000, 32'h9000, 0, 0);
    fetch(32'h2000);
    checks++; if (pred_valid !== 1'b1 || pred_ckpt !== 7'h01) begin failures++; $display("FAIL t5_c0 got=%0h/%0h exp=1/1", pred_valid, pred_ckpt); end
    fetch(32'h1000);
    checks++; if (pred_ckpt !== 7'h0A) begin failures++; $display("FAIL t5_push got=%0h exp=a", pred_ckpt); end
    drive_upd(0, 0, 2'd0, 0, 32'h2000, 32'h0, 1, 7'h01);
    checks++; if (pred_ckpt !== 7'h01) begin failures++; $display("FAIL t5_restore got=%0h exp=1", pred_ckpt); end
    drive_upd(0, 0, 2'd2, 1, 32'h3000, 32'hA000, 1, 7'h01);
    checks++; if (pred_ckpt !== 7'h0A) begin failures++; $display("FAIL t5_rec_call got=%0h exp=a", pred_ckpt); end
    fetch(32'h1C00_0200);
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h3004) begin failures++; $display("FAIL t5_rec_ret got=%0h/%0h exp=1/3004", pred_taken, pred_target); end
    tick();
    checks++; if (pred_ckpt !== 7'h01) begin failures++; $display("FAIL t5_end_ckpt got=%0h exp=1", pred_ckpt); end
  endtask

  task automatic test_victim_inv();
    drive_upd(1, 0, 2'd0, 1, 32'h1C00_0010, 32'h1C00_0100, 0, 0);
    for (int k = 0; k < 18; k++) drive_upd(0, 0, 2'd1, 1, 32'h4000 + 32'(4*k), 32'h7000, 0, 0);
    fetch(32'h4000);
    checks++; if (pred_valid !== 1'b1 || pred_index !== 5'd14) begin failures++; $display("FAIL t6_fill got=%0h/%0h exp=1/e", pred_valid, pred_index); end
    for (int k = 0; k < 3; k++) drive_upd(1, 5, 2'd0, 0, 32'h1020, 32'h8000, 0, 0);
    drive_upd(0, 0, 2'd0, 1, 32'h5000, 32'h5100, 0, 0);
    fetch(32'h5000);
    checks++; if (pred_valid !== 1'b1 || pred_index !== 5'd5) begin failures++; $display("FAIL t6_victim got=%0h/%0h exp=1/5", pred_valid, pred_index); end
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h5100) begin failures++; $display("FAIL t6_new got=%0h/%0h exp=1/5100", pred_taken, pred_target); end
    fetch(32'h1020);
    checks++; if (pred_valid !== 1'b0) begin failures++; $display("FAIL t6_evicted got=%0h exp=0", pred_valid); end
    fetch(32'h1C00_0010);
    checks++; if (pred_valid !== 1'b1 || pred_index !== 5'd0) begin failures++; $display("FAIL t6_pre_inv got=%0h/%0h exp=1/0", pred_valid, pred_index); end
    inv_all = 1'b1; fetch_en = 1'b1; fetch_pc = 32'h1C00_0010;
    drive_upd(0, 0, 2'd1, 1, 32'h6000, 32'h6100, 0, 0);
    inv_all = 1'b0; fetch_en = 1'b0;
    checks++; if (pred_valid !== 1'b0) begin failures++; $display("FAIL t6_inv_valid got=%0h exp=0", pred_valid); end
    checks++; if (pred_ckpt !== 7'd0) begin failures++; $display("FAIL t6_inv_ckpt got=%0h exp=0", pred_ckpt); end
    fetch(32'h6000);
    checks++; if (pred_valid !== 1'b0) begin failures++; $display("FAIL t6_inv_alloc got=%0h exp=0", pred_valid); end
    fetch(32'h1000);
    checks++; if (pred_valid !== 1'b0) begin failures++; $display("FAIL t6_inv_call got=%0h exp=0", pred_valid); end
  endtask

  initial begin
    test_reset();
    test_cond();
    test_call_return();
    test_back_to_back();
    test_recovery();
    test_victim_inv();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btb_ras_pred.md
Name: btb_ras_pred

Overview:
- Parametrised next-generation branch target buffer with an integrated speculative, checkpointed return-address stack.
- Sits beside the IF stage. It takes the fetch PC and returns a registered prediction one cycle later.
- Accepts resolved-branch updates from ID/EX, including RAS recovery on mispredict.
- Generalises entry count and RAS depth, adds per-entry branch type, circular RAS overflow, and checkpoint restore.

Parameters:
BTB_ENTRIES, 32, number of fully-associative BTB entries; power of 2, 4..64
RAS_DEPTH, 8, return-stack entries; power of 2, 2..32
IDX_W, $clog2(BTB_ENTRIES), entry index width (derived)
RP_W, $clog2(RAS_DEPTH), RAS pointer width (derived)
CK_W, 2*RP_W+1, RAS checkpoint width {count[RP_W:0], top[RP_W-1:0]} (derived)

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
fetch_en  in  1  lookup request this cycle
fetch_pc  in  32  PC to look up
pred_valid  out  1  BTB hit for last cycle's lookup
pred_taken  out  1  predicted direction
pred_target  out  32  predicted target, [1:0]=0
pred_index  out  IDX_W  hitting entry index
pred_type  out  2  0 cond, 1 jump, 2 call, 3 return
pred_ckpt  out  CK_W  RAS state before this prediction's push/pop
upd_en  in  1  resolved branch update
upd_pc  in  32  branch PC
upd_hit  in  1  branch had a BTB hit (upd_index valid)
upd_index  in  IDX_W  entry from pred_index
upd_type  in  2  actual branch type
upd_taken  in  1  actual direction
upd_target  in  32  actual target
upd_mispredict  in  1  direction/target/type mispredicted; restore RAS
upd_ckpt  in  CK_W  checkpoint carried with the branch
inv_all  in  1  invalidate all BTB entries and empty the RAS

Behaviour:
- Reset (resetn=0 at edge):
  - All valids 0; RAS count 0, top 0.
  - LFSR = 6'b100010.
  - Registered fetch state 0, so every pred_* output reads 0 from the next cycle.
- Entry contents: valid, tag=pc[31:2], target[31:2], type[1:0], ctr[1:0].
- Lookup:
  - fetch_en/fetch_pc are registered at cycle t. Compare occurs in t+1 against array contents at t+1; writes from edge t are visible.
  - pred_valid = fetch_en_r & hit. At most one hit; allocation guarantees a unique tag. If multiple tags match anyway, the lowest index wins.
  - pred_taken:
    - cond: ctr[1].
    - jump and call: 1.
    - return: RAS count != 0.
  - pred_target: RAS top entry for a return with count != 0, else the stored target.
  - On miss, all pred_* outputs are 0 except pred_ckpt, which always shows the current RAS state.
- Speculative RAS (circular):
  - Triggered when pred_valid is high and no mispredict occurs in the same cycle.
  - call: write fetch_pc_r+4 at top+1, top++, count = min(count+1, RAS_DEPTH). Overflow overwrites the oldest entry.
  - return with count != 0: top--, count--.
  - return with count 0: no change.
  - top wraps modulo RAS_DEPTH.
- Recovery (upd_en & upd_mispredict):
  - Restore {count, top} from upd_ckpt, then apply the actual upd_type action: call pushes upd_pc+4, return pops if the restored count != 0.
  - This has priority over the same-cycle speculative push/pop, which is dropped.
  - RAS data entries are never restored.
- BTB update (upd_en):
  - upd_hit=1:
    - Write type and target.
    - cond: ctr saturating +1 if taken, -1 if not taken.
    - non-cond: ctr=11.
    - If cond, not taken, and ctr is already 00, the entry is kept (not invalidated).
  - upd_hit=0 & upd_taken: allocate with tag, target, type; ctr=10 for cond, 11 otherwise.
    - Victim priority: lowest invalid entry; else lowest valid cond entry with ctr=00; else LFSR[IDX_W-1:0] (bits replicated when IDX_W > 6).
  - upd_hit=0 & !upd_taken: no allocation.
- LFSR: free-running every cycle with taps equivalent to x^6+x^4+x^3+1.
- inv_all: clears valids, count and top next edge. It overrides a same-cycle update/allocation and any RAS action. Lookup in the following cycle misses.

Test Plan:
1. Reset, then fetch_en with pc 0x1C000000 -> next cycle pred_valid=0, pred_ckpt=0.
2. Update (upd_hit=0, type cond, taken, pc 0x1C000010, target 0x1C000100), then fetch 0x1C000010 -> pred_valid=1, taken=1, target 0x1C000100, index 0. Two not-taken updates -> ctr 00, pred_taken=0, pred_valid=1.
3. Allocate a call at 0x1C000020 and a return at 0x1C000200. Fetch the call (ckpt=0), then the return -> return pred_target=0x1C000024, taken=1. A second return -> taken=0.
4. RAS_DEPTH=8: 9 predicted calls from pc 0x1000+16k (k=0..8) -> count=8. 8 returns yield 0x1084 down to 0x1014; the 9th return predicts not taken.
5. Predicted call at 0x2000 (ckpt C0) then upd_mispredict with upd_ckpt=C0, type cond, in the same cycle as another predicted call -> RAS state equals C0; the speculative push is dropped.
6. Fill all BTB_ENTRIES, make entry 5 cond ctr=00, allocate a new branch -> lands in index 5. inv_all in the same cycle as an update -> all lookups miss next cycle.
